// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, legality/range limits and sequencer FSM
// state encodings for the SixteenBit_ALU front-end.
package alu_pkg;

  localparam logic [5:0] OP_CLR  = 6'd0;
  localparam logic [5:0] OP_NOT  = 6'd1;
  localparam logic [5:0] OP_SHR  = 6'd2;
  localparam logic [5:0] OP_SHL  = 6'd3;
  localparam logic [5:0] OP_FACT = 6'd4;
  localparam logic [5:0] OP_EXP  = 6'd5;
  localparam logic [5:0] OP_ADD  = 6'd6;
  localparam logic [5:0] OP_SUB  = 6'd7;
  localparam logic [5:0] OP_MULT = 6'd8;
  localparam logic [5:0] OP_DIV  = 6'd9;
  localparam logic [5:0] OP_AND  = 6'd10;
  localparam logic [5:0] OP_OR   = 6'd11;
  localparam logic [5:0] OP_XOR  = 6'd12;

  localparam logic [5:0] MAX_OP = OP_XOR;

  // Largest operands whose factorial / e^x fit the 32-bit ALU result.
  localparam logic [15:0] FACT_MAX = 16'd12;
  localparam logic [15:0] EXP_MAX  = 16'd22;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_errchk.sv
// alu_op_errchk: combinational op classifier.
//  op      in  6   opcode
//  a, b    in  16  operands as they will be issued to the ALU
//  err     out 1   response error flag for this op
//  is_long out 1   op needs the long settle time
//  legal   out 1   op is issued to the ALU (else alu_sel forced to clear)
// With ALU_SEQ_DIV0_TRAP_EN defined, divide-by-zero is not issued and is
// handled like an illegal opcode.
module alu_op_errchk
  import alu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        err,
  output logic        is_long,
  output logic        legal
);

  logic [16:0] sum;
  logic        div0;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    div0 = (op == OP_DIV) && (b == 16'd0);
`ifdef ALU_SEQ_DIV0_TRAP_EN
    legal = (op <= MAX_OP) && !div0;
`else
    legal = (op <= MAX_OP);
`endif
    err = 1'b0;
    case (op)
      OP_ADD:  err = sum[16];
      OP_SUB:  err = (a < b);
      OP_DIV:  err = div0;
      OP_FACT: err = (a > FACT_MAX);
      OP_EXP:  err = (a > EXP_MAX);
      default: err = 1'b0;
    endcase
    if (!legal) err = 1'b1;
    is_long = legal && ((op == OP_FACT) || (op == OP_EXP) ||
                        (op == OP_MULT) || (op == OP_DIV));
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end and accumulator around SixteenBit_ALU.
// Accepts one op per cmd handshake, drives the ALU inputs, waits the op's
// settle time, captures alu_out into acc and returns it on the rsp handshake.
//  clk, reset            clock; synchronous active-low reset
//  cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//  cmd_op/a/b/use_acc    command; use_acc takes A from acc[15:0]
//  alu_a/alu_b/alu_sel   registered ALU inputs, stable during WAIT
//  alu_out               ALU result
//  rsp_valid/rsp_ready   response handshake
//  rsp_data/rsp_err      captured result and error flag
//  acc, busy             accumulator; state != IDLE
// Build option ALU_SEQ_DIV0_TRAP_EN: divide-by-zero is trapped (not issued).
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SHORT_WAIT = 1,
  parameter int LONG_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_use_acc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [5:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] acc,
  output logic        busy
);

  localparam int WMAX = (SHORT_WAIT > LONG_WAIT) ? SHORT_WAIT : LONG_WAIT;
  localparam int CW   = $clog2(WMAX + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          legal_q;
  logic          accept, capture;
  logic [15:0]   a_sel;
  logic          chk_err, chk_long, chk_legal;

  assign a_sel = cmd_use_acc ? acc[15:0] : cmd_a;

  alu_op_errchk u_errchk (
    .op      (cmd_op),
    .a       (a_sel),
    .b       (cmd_b),
    .err     (chk_err),
    .is_long (chk_long),
    .legal   (chk_legal)
  );

  always_comb begin
    state_n   = state;
    cmd_ready = (state == S_IDLE);
    accept    = 1'b0;
    capture   = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (cmd_valid) begin
        accept  = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: if (cnt == CW'(1)) begin
        capture = 1'b1;
        state_n = S_RESP;
      end
      S_RESP: if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      legal_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        alu_a   <= a_sel;
        alu_b   <= cmd_b;
        alu_sel <= chk_legal ? cmd_op : OP_CLR;
        legal_q <= chk_legal;
        rsp_err <= chk_err;
        cnt     <= chk_long ? CW'(LONG_WAIT) : CW'(SHORT_WAIT);
      end
      if (state == S_WAIT) cnt <= cnt - CW'(1);
      if (capture) begin
        rsp_valid <= 1'b1;
        // Ops never issued to the ALU leave acc alone and report zero.
        if (legal_q) begin
          acc      <= alu_out;
          rsp_data <= alu_out;
        end else begin
          rsp_data <= '0;
        end
      end
      if (state == S_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [5:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_use_acc;
  logic [15:0] alu_a, alu_b;
  logic [5:0]  alu_sel;
  logic [31:0] alu_out;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] acc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .acc(acc), .busy(busy)
  );

  // ---------------- behavioural ALU ----------------
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] f;
    logic [15:0] t;
    case (op)
      6'd0:  return 32'd0;
      6'd1:  return {16'h0, ~a};
      6'd2:  return {16'h0, a >> b[3:0]};
      6'd3:  begin t = a << b[3:0]; return {16'h0, t}; end
      6'd4:  begin
        if (a > 16'd40) return 32'd0;
        f = 32'd1;
        for (int i = 2; i <= int'(a); i++) f = f * 32'(i);
        return f;
      end
      6'd5:  begin
        if (a > 16'd22) return 32'hFFFF_FFFF;
        return 32'(longint'($floor($exp(real'(a)))));
      end
      6'd6:  begin t = a + b; return {16'h0, t}; end
      6'd7:  begin t = a - b; return {16'h0, t}; end
      6'd8:  return 32'(a) * 32'(b);
      6'd9:  return (b == 16'd0) ? 32'hFFFF_FFFF : 32'(a / b);
      6'd10: return {16'h0, a & b};
      6'd11: return {16'h0, a | b};
      6'd12: return {16'h0, a ^ b};
      default: return 32'd0;
    endcase
  endfunction

  function automatic int settle(input logic [5:0] op);
    return (op == 6'd4 || op == 6'd5 || op == 6'd8 || op == 6'd9) ? 4 : 1;
  endfunction

  // The ALU output is garbage until its inputs have been stable long enough,
  // so a capture that comes too early shows up as a wrong result.
  logic [37:0] prev_in = '0;
  int          age = 0;
  always @(negedge clk) begin
    if ({alu_a, alu_b, alu_sel} != prev_in) age <= 1;
    else if (age < 100) age <= age + 1;
    prev_in <= {alu_a, alu_b, alu_sel};
  end
  always_comb alu_out = (age >= settle(alu_sel)) ? alu_fn(alu_sel, alu_a, alu_b) : 32'hDEAD_BEEF;

  // ---------------- reference model ----------------
  function automatic logic trapped(input logic [5:0] op, input logic [15:0] b);
`ifdef ALU_SEQ_DIV0_TRAP_EN
    return (op == 6'd9) && (b == 16'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [5:0] exp_sel(input logic [5:0] op, input logic [15:0] b);
    if (op > 6'd12 || trapped(op, b)) return 6'd0;
    return op;
  endfunction

  task automatic model(input logic [5:0] op, input logic [15:0] a_in, input logic [15:0] b,
                       input logic ua, inout logic [31:0] acc_m,
                       output logic [31:0] data, output logic err, output int lat);
    logic [15:0] a;
    a = ua ? acc_m[15:0] : a_in;
    case (op)
      6'd6:    err = (int'(a) + int'(b)) > 65535;
      6'd7:    err = a < b;
      6'd9:    err = b == 0;
      6'd4:    err = a > 12;
      6'd5:    err = a > 22;
      default: err = (op > 6'd12);
    endcase
    if (op > 6'd12 || trapped(op, b)) begin
      data = 32'd0;
      lat  = 1;
    end else begin
      data  = alu_fn(op, a, b);
      acc_m = data;
      lat   = settle(op);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle.
  task automatic do_op(input string nm, input logic [5:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ua, input logic [31:0] e_data,
                       input logic e_err, input logic [31:0] e_acc, input int e_lat);
    int lat;
    chk({nm, ".cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_op = 6'($urandom);
    chk({nm, ".alu_sel"}, alu_sel, exp_sel(op, b));
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      errors++; checks++;
      $display("FAIL %s.timeout no rsp_valid after %0d cycles", nm, lat);
    end else begin
      chk({nm, ".latency"}, lat, e_lat);
      chk({nm, ".rsp_data"}, rsp_data, e_data);
      chk({nm, ".rsp_err"}, rsp_err, e_err);
      chk({nm, ".acc"}, acc, e_acc);
      chk({nm, ".busy"}, busy, 1);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({nm, ".rsp_drop"}, rsp_valid, 0);
    chk({nm, ".idle"}, busy, 0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a, b;
    logic        ua;
    logic [31:0] data;
    logic        err;
    logic [31:0] acc;
    int          lat;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic [31:0] acc_m, e_data;
    logic        e_err;
    int          e_lat, n;
    logic        saw;
    logic [5:0]  rop;
    logic [15:0] ra, rb;
    logic        rua;

    tv.push_back('{6'd6,  16'd3,      16'd4,      1'b0, 32'd7,          1'b0, 32'd7,          1});
    tv.push_back('{6'd6,  16'd999,    16'd5,      1'b1, 32'd12,         1'b0, 32'd12,         1});
    tv.push_back('{6'd6,  16'hFFFF,   16'd1,      1'b0, 32'd0,          1'b1, 32'd0,          1});
    tv.push_back('{6'd7,  16'd2,      16'd5,      1'b0, 32'h0000_FFFD,  1'b1, 32'h0000_FFFD,  1});
    tv.push_back('{6'd4,  16'd5,      16'd0,      1'b0, 32'd120,        1'b0, 32'd120,        4});
    tv.push_back('{6'd4,  16'd13,     16'd0,      1'b0, 32'h7328_CC00,  1'b1, 32'h7328_CC00,  4});
    tv.push_back('{6'd13, 16'd1,      16'd1,      1'b0, 32'd0,          1'b1, 32'h7328_CC00,  1});
    tv.push_back('{6'd8,  16'd300,    16'd1000,   1'b0, 32'd300000,     1'b0, 32'd300000,     4});
    tv.push_back('{6'd9,  16'd100,    16'd7,      1'b0, 32'd14,         1'b0, 32'd14,         4});
`ifdef ALU_SEQ_DIV0_TRAP_EN
    tv.push_back('{6'd9,  16'd5,      16'd0,      1'b0, 32'd0,          1'b1, 32'd14,         1});
`else
    tv.push_back('{6'd9,  16'd5,      16'd0,      1'b0, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  4});
`endif
    tv.push_back('{6'd0,  16'd77,     16'd88,     1'b0, 32'd0,          1'b0, 32'd0,          1});
    tv.push_back('{6'd12, 16'hF0F0,   16'hFF00,   1'b0, 32'h0000_0FF0,  1'b0, 32'h0000_0FF0,  1});
    tv.push_back('{6'd10, 16'hF0F0,   16'hFF00,   1'b0, 32'h0000_F000,  1'b0, 32'h0000_F000,  1});
    tv.push_back('{6'd11, 16'hF0F0,   16'hFF00,   1'b0, 32'h0000_FFF0,  1'b0, 32'h0000_FFF0,  1});
    tv.push_back('{6'd1,  16'h00FF,   16'd0,      1'b0, 32'h0000_FF00,  1'b0, 32'h0000_FF00,  1});
    tv.push_back('{6'd5,  16'd2,      16'd0,      1'b0, 32'd7,          1'b0, 32'd7,          4});
    tv.push_back('{6'd5,  16'd23,     16'd0,      1'b0, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  4});
    tv.push_back('{6'd2,  16'h0010,   16'd2,      1'b0, 32'h0000_0004,  1'b0, 32'h0000_0004,  1});
    tv.push_back('{6'd3,  16'h0001,   16'd4,      1'b0, 32'h0000_0010,  1'b0, 32'h0000_0010,  1});

    reset = 0; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_use_acc = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    chk("reset.acc", acc, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.cmd_ready", cmd_ready, 1);
    chk("reset.busy", busy, 0);
    chk("reset.rsp_data", rsp_data, 0);
    chk("reset.alu_sel", alu_sel, 0);

    foreach (tv[i])
      do_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].ua,
            tv[i].data, tv[i].err, tv[i].acc, tv[i].lat);

    // randomized ops against the model
    acc_m = tv[tv.size()-1].acc;
    for (int k = 0; k < 60; k++) begin
      rop = 6'($urandom_range(0, 14));
      ra  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 30)) : 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      rua = ($urandom_range(0, 3) == 0);
      model(rop, ra, rb, rua, acc_m, e_data, e_err, e_lat);
      do_op($sformatf("rnd%0d", k), rop, ra, rb, rua, e_data, e_err, acc_m, e_lat);
    end

    // response back-pressure: rsp held, second command ignored
    cmd_valid = 1; cmd_op = 6'd6; cmd_a = 16'd10; cmd_b = 16'd20; cmd_use_acc = 0;
    @(posedge clk); #1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (n == 0) cmd_op = 6'd0;   // keep cmd_valid high with a clear op
      @(posedge clk); #1;
      n++;
    end
    chk("hold.rsp_valid", rsp_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold.valid", rsp_valid, 1);
      chk("hold.data", rsp_data, 30);
      chk("hold.err", rsp_err, 0);
      chk("hold.cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("hold.rsp_drop", rsp_valid, 0);
    chk("hold.acc", acc, 30);
    saw = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || rsp_valid) saw = 1;
    end
    chk("hold.no_second_op", saw, 0);

    // reset in the middle of a long wait
    cmd_valid = 1; cmd_op = 6'd8; cmd_a = 16'd3; cmd_b = 16'd3;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    chk("midrst.busy_before", busy, 1);
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    chk("midrst.busy", busy, 0);
    chk("midrst.acc", acc, 0);
    chk("midrst.rsp_valid", rsp_valid, 0);
    chk("midrst.rsp_data", rsp_data, 0);
    chk("midrst.alu_sel", alu_sel, 0);
    chk("midrst.cmd_ready", cmd_ready, 1);
    saw = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1;
    end
    chk("midrst.no_rsp", saw, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
